// File: rtl/data_memory.sv
// Byte-wide data memory with a fixed multi-cycle access latency and a CPU stall
// handshake: IDLE accepts a request, BUSY counts down, DONE releases the stall.
module data_memory #(
    parameter int LATENCY = 5,
    parameter int DEPTH   = 256
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       READ,
    input  logic       WRITE,
    input  logic [7:0] ADDRESS,
    input  logic [7:0] WRITE_DATA,
    output logic [7:0] READ_DATA,
    output logic       BUSYWAIT
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // The request cycle in IDLE is the first stalled cycle, so BUSY lasts LATENCY-1 cycles.
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 2);

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] count_r;
    logic [7:0] addr_r;
    logic [7:0] wdata_r;
    logic       is_write_r;
    logic [7:0] mem_r [DEPTH];

    logic       start_s;
    logic       last_s;
    logic       busywait_s;

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (READ || WRITE) begin
                    next_state_s = BUSY;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY: begin
                if (count_r == 4'd0) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = BUSY;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output and control decode
    always_comb begin
        busywait_s = 1'b0;
        start_s    = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            IDLE: begin
                busywait_s = READ | WRITE;
                start_s    = READ | WRITE;
            end
            BUSY: begin
                busywait_s = 1'b1;
                last_s     = (count_r == 4'd0);
            end
            DONE: begin
                busywait_s = 1'b0;
            end
            default: begin
                busywait_s = 1'b0;
            end
        endcase
    end

    // The stall must drop while reset is held even if the CPU keeps requesting.
    assign BUSYWAIT = busywait_s & RESET;

    // Request capture and latency counter; inputs are frozen once the access starts
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_r    <= 4'd0;
            addr_r     <= 8'h00;
            wdata_r    <= 8'h00;
            is_write_r <= 1'b0;
        end else if (start_s) begin
            count_r    <= COUNT_LOAD;
            addr_r     <= ADDRESS;
            wdata_r    <= WRITE_DATA;
            is_write_r <= WRITE & ~READ;
        end else if ((state_r == BUSY) && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end
    end

    // Read data register, updated only when a read completes
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            READ_DATA <= 8'h00;
        end else if (last_s && !is_write_r) begin
            READ_DATA <= mem_r[addr_r];
        end
    end

    // Storage array, cleared by reset and written when a write completes
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (last_s && is_write_r) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: scoreboarded reads against a byte model,
// stall-length measurement, mid-access disturbance, reset abort and back-to-back traffic.
module tb_data_memory;

    localparam int LAT = 5;

    logic       CLK;
    logic       RESET;
    logic       READ;
    logic       WRITE;
    logic [7:0] ADDRESS;
    logic [7:0] WRITE_DATA;
    logic [7:0] READ_DATA;
    logic       BUSYWAIT;

    int         n_pass;
    int         n_total;
    logic [7:0] model [256];
    logic [7:0] exp_q [$];
    logic [7:0] last_rd;

    data_memory #(.LATENCY(LAT), .DEPTH(256)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .READ       (READ),
        .WRITE      (WRITE),
        .ADDRESS    (ADDRESS),
        .WRITE_DATA (WRITE_DATA),
        .READ_DATA  (READ_DATA),
        .BUSYWAIT   (BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drives one access and measures how many sampled cycles BUSYWAIT stayed high.
    // At busy cycle chg_at the address/data are disturbed and optionally the request dropped.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input int chg_at, input logic [7:0] a2, input logic [7:0] d2,
                          input logic drop, output int bc, output logic [7:0] rdat);
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = a; WRITE_DATA = d;
        #1;
        bc = 0;
        while (BUSYWAIT === 1'b1 && bc < 40) begin
            bc++;
            @(negedge CLK);
            if (bc == chg_at) begin
                ADDRESS = a2; WRITE_DATA = d2;
                if (drop) begin
                    READ = 1'b0; WRITE = 1'b0;
                end
            end
            #1;
        end
        rdat = READ_DATA;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b0; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h00; WRITE_DATA = 8'h00;
        repeat (3) @(negedge CLK);
        #1;
        n_total++;
        if (BUSYWAIT !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSYWAIT);
        else n_pass++;
        n_total++;
        if (READ_DATA !== 8'h00) $display("FAIL reset_rdata: got %h want 00", READ_DATA);
        else n_pass++;
        READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        n_total++;
        if (BUSYWAIT !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", BUSYWAIT);
        else n_pass++;
    endtask

    task automatic test_write_read;
        int bc; logic [7:0] rd; logic [7:0] e;
        access(1'b0, 1'b1, 8'h10, 8'hA5, -1, 8'h00, 8'h00, 1'b0, bc, rd);
        model[8'h10] = 8'hA5;
        n_total++;
        if (bc !== LAT) $display("FAIL wr_busy_len: got %0d want %0d", bc, LAT);
        else n_pass++;
        exp_q.push_back(model[8'h10]);
        access(1'b1, 1'b0, 8'h10, 8'h00, -1, 8'h00, 8'h00, 1'b0, bc, rd);
        e = exp_q.pop_front(); last_rd = e;
        n_total++;
        if (bc !== LAT) $display("FAIL rd_busy_len: got %0d want %0d", bc, LAT);
        else n_pass++;
        n_total++;
        if (rd !== e) $display("FAIL rd_0x10: got %h want %h", rd, e);
        else n_pass++;
    endtask

    task automatic test_mid_change;
        int bc; logic [7:0] rd; logic [7:0] e;
        access(1'b0, 1'b1, 8'h20, 8'h3C, 2, 8'h21, 8'hFF, 1'b0, bc, rd);
        model[8'h20] = 8'h3C;
        n_total++;
        if (bc !== LAT) $display("FAIL mid_busy_len: got %0d want %0d", bc, LAT);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            logic [7:0] a;
            a = (k == 0) ? 8'h20 : 8'h21;
            exp_q.push_back(model[a]);
            access(1'b1, 1'b0, a, 8'h00, 2, 8'hEE, 8'h00, 1'b0, bc, rd);
            e = exp_q.pop_front(); last_rd = e;
            n_total++;
            if (rd !== e) $display("FAIL mid_rd_%h: got %h want %h", a, rd, e);
            else n_pass++;
        end
    endtask

    task automatic test_drop;
        int bc; logic [7:0] rd; logic [7:0] e;
        access(1'b0, 1'b1, 8'h50, 8'h66, 1, 8'h50, 8'h66, 1'b1, bc, rd);
        model[8'h50] = 8'h66;
        n_total++;
        if (bc !== LAT) $display("FAIL drop_busy_len: got %0d want %0d", bc, LAT);
        else n_pass++;
        exp_q.push_back(model[8'h50]);
        access(1'b1, 1'b0, 8'h50, 8'h00, -1, 8'h00, 8'h00, 1'b0, bc, rd);
        e = exp_q.pop_front(); last_rd = e;
        n_total++;
        if (rd !== e) $display("FAIL drop_rd: got %h want %h", rd, e);
        else n_pass++;
    endtask

    task automatic test_simul;
        int bc; logic [7:0] rd; logic [7:0] e;
        access(1'b0, 1'b1, 8'h30, 8'h11, -1, 8'h00, 8'h00, 1'b0, bc, rd);
        model[8'h30] = 8'h11;
        exp_q.push_back(model[8'h30]);
        access(1'b1, 1'b1, 8'h30, 8'h99, -1, 8'h00, 8'h00, 1'b0, bc, rd);
        e = exp_q.pop_front(); last_rd = e;
        n_total++;
        if (rd !== e) $display("FAIL simul_rd: got %h want %h", rd, e);
        else n_pass++;
        exp_q.push_back(model[8'h30]);
        access(1'b1, 1'b0, 8'h30, 8'h00, -1, 8'h00, 8'h00, 1'b0, bc, rd);
        e = exp_q.pop_front(); last_rd = e;
        n_total++;
        if (rd !== e) $display("FAIL simul_mem: got %h want %h", rd, e);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int bc; logic [7:0] rd; logic [7:0] e;
        @(negedge CLK);
        WRITE = 1'b1; READ = 1'b0; ADDRESS = 8'h40; WRITE_DATA = 8'h77;
        repeat (3) @(negedge CLK);
        #1;
        n_total++;
        if (BUSYWAIT !== 1'b1) $display("FAIL rstmid_pre_busy: got %b want 1", BUSYWAIT);
        else n_pass++;
        RESET = 1'b0;
        #1;
        n_total++;
        if (BUSYWAIT !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", BUSYWAIT);
        else n_pass++;
        n_total++;
        if (READ_DATA !== 8'h00) $display("FAIL rstmid_rdata: got %h want 00", READ_DATA);
        else n_pass++;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        last_rd = 8'h00;
        @(negedge CLK);
        WRITE = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        for (int k = 0; k < 2; k++) begin
            logic [7:0] a;
            a = (k == 0) ? 8'h40 : 8'h10;
            exp_q.push_back(model[a]);
            access(1'b1, 1'b0, a, 8'h00, -1, 8'h00, 8'h00, 1'b0, bc, rd);
            e = exp_q.pop_front(); last_rd = e;
            n_total++;
            if (bc !== LAT) $display("FAIL rstmid_len_%h: got %0d want %0d", a, bc, LAT);
            else n_pass++;
            n_total++;
            if (rd !== e) $display("FAIL rstmid_rd_%h: got %h want %h", a, rd, e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] trace; int phase; int bc; logic [7:0] rd; logic [7:0] e;
        @(negedge CLK);
        READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'hFF;
        exp_q.push_back(model[8'hFF]);
        phase = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            trace[11-i] = BUSYWAIT;
            if (BUSYWAIT === 1'b0 && phase == 0) begin
                e = exp_q.pop_front(); last_rd = e;
                n_total++;
                if (READ_DATA !== e) $display("FAIL b2b_rd_ff: got %h want %h", READ_DATA, e);
                else n_pass++;
                READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h00; WRITE_DATA = 8'h5A;
                model[8'h00] = 8'h5A;
                phase = 1;
            end else if (BUSYWAIT === 1'b0 && phase == 1) begin
                WRITE = 1'b0;
                phase = 2;
            end
            @(negedge CLK);
        end
        n_total++;
        if (trace !== 12'b1111_1011_1110) $display("FAIL b2b_pattern: got %b want 111110111110", trace);
        else n_pass++;
        exp_q.push_back(model[8'h00]);
        access(1'b1, 1'b0, 8'h00, 8'h00, -1, 8'h00, 8'h00, 1'b0, bc, rd);
        e = exp_q.pop_front(); last_rd = e;
        n_total++;
        if (rd !== e) $display("FAIL b2b_rd_00: got %h want %h", rd, e);
        else n_pass++;
        access(1'b0, 1'b1, 8'hFF, 8'hC3, -1, 8'h00, 8'h00, 1'b0, bc, rd);
        model[8'hFF] = 8'hC3;
        n_total++;
        if (rd !== last_rd) $display("FAIL wr_holds_rdata: got %h want %h", rd, last_rd);
        else n_pass++;
        exp_q.push_back(model[8'hFF]);
        access(1'b1, 1'b0, 8'hFF, 8'h00, -1, 8'h00, 8'h00, 1'b0, bc, rd);
        e = exp_q.pop_front(); last_rd = e;
        n_total++;
        if (rd !== e) $display("FAIL rd_top_addr: got %h want %h", rd, e);
        else n_pass++;
    endtask

    task automatic test_idle_hold;
        READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h33; WRITE_DATA = 8'h44;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            #1;
            n_total++;
            if (BUSYWAIT !== 1'b0 || READ_DATA !== last_rd)
                $display("FAIL idle_hold_%0d: got busy=%b rdata=%h want busy=0 rdata=%h",
                         i, BUSYWAIT, READ_DATA, last_rd);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0; n_total = 0; last_rd = 8'h00;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        test_reset;
        test_write_read;
        test_mid_change;
        test_drop;
        test_simul;
        test_reset_mid;
        test_back_to_back;
        test_idle_hold;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter LATENCY, default 5, meaning the number of cycles BUSYWAIT stays high per access (legal range 2..15).
REQ-002 SHALL have parameter DEPTH, default 256, meaning the number of 8-bit storage locations, addressed by the full 8-bit ADDRESS.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 SHALL have port READ  input  1  read request from the CPU, held high until the access completes.
REQ-006 SHALL have port WRITE  input  1  write request from the CPU, held high until the access completes.
REQ-007 SHALL have port ADDRESS  input  8  byte address of the access.
REQ-008 SHALL have port WRITE_DATA  input  8  data to be stored on a write.
REQ-009 SHALL have port READ_DATA  output  8  registered data returned by a read.
REQ-010 SHALL have port BUSYWAIT  output  1  stall signal to the CPU; high while an access is in progress.

Function
REQ-011 SHALL implement three states: IDLE, BUSY and DONE.
REQ-012 In IDLE, BUSYWAIT SHALL equal (READ | WRITE) combinationally, so the CPU stalls in the same cycle its request appears.
REQ-013 On a rising edge in IDLE with READ or WRITE high, the block SHALL latch ADDRESS, WRITE_DATA and the operation type, load the latency counter and enter BUSY.
REQ-014 With READ and WRITE both high in IDLE, the access SHALL be treated as a read and no write SHALL occur.
REQ-015 In BUSY, BUSYWAIT SHALL be 1 and the counter SHALL decrement once per rising edge.
REQ-016 BUSYWAIT SHALL be high for exactly LATENCY consecutive cycles, counted from the first cycle the request is visible in IDLE.
REQ-017 On the rising edge ending the last BUSY cycle, the block SHALL complete the access and enter DONE.
- Read completion: the latched-address location is loaded into READ_DATA.
- Write completion: the latched WRITE_DATA is stored at the latched address.
REQ-018 In DONE, BUSYWAIT SHALL be 0 for exactly one cycle, READ/WRITE SHALL be ignored, and the next rising edge SHALL return the block to IDLE.
REQ-019 Changes to ADDRESS, WRITE_DATA, READ or WRITE while in BUSY SHALL have no effect on the access in progress.
REQ-020 If READ and WRITE both drop while in BUSY, the access SHALL still complete normally (no abort).
REQ-021 READ_DATA SHALL change only on a read completion and SHALL hold its value otherwise, including across writes.
REQ-022 A read of a location written by the immediately preceding access SHALL return the newly written value.
REQ-023 Back-to-back accesses SHALL be supported: a request present in the cycle after DONE starts a new access, with BUSYWAIT high combinationally again.
REQ-024 All addresses 0x00..0xFF SHALL be valid; there is no wrap or out-of-range behaviour.

Reset
REQ-025 While RESET=0, independent of CLK, the block SHALL hold:
- state = IDLE, counter = 0, READ_DATA = 0x00
- BUSYWAIT = 0, regardless of READ/WRITE
- all DEPTH locations = 0x00
REQ-026 A RESET assertion during BUSY SHALL abort the access: no write is performed and READ_DATA = 0x00.
REQ-027 After RESET returns to 1, the first rising edge with READ or WRITE high SHALL start a fresh access per REQ-013.

Verification
REQ-028 Write then read, LATENCY=5: WRITE=1, ADDRESS=0x10, WRITE_DATA=0xA5. SHALL see BUSYWAIT high for 5 cycles, then low for 1 cycle. Then READ=1, ADDRESS=0x10. SHALL see READ_DATA=0xA5 in the DONE cycle, after another 5 busy cycles.
REQ-029 Mid-access input change: during BUSY of a write to 0x20 with data 0x3C, change ADDRESS to 0x21 and WRITE_DATA to 0xFF. Subsequent reads SHALL give mem[0x20]=0x3C and mem[0x21]=0x00.
REQ-030 Simultaneous READ=1 and WRITE=1 at 0x30 (preloaded 0x11), WRITE_DATA=0x99. SHALL see READ_DATA=0x11, and mem[0x30] SHALL remain 0x11.
REQ-031 Reset mid-write: assert RESET=0 in the 3rd BUSY cycle of a write of 0x77 to 0x40. SHALL see BUSYWAIT=0 immediately; a later read of 0x40 SHALL return 0x00.
REQ-032 Back-to-back requests: hold READ at 0xFF, then immediately issue WRITE at 0x00 with 0x5A. SHALL see the busy pattern 5-high/1-low/5-high/1-low, and mem[0x00]=0x5A.
REQ-033 Idle hold: with READ=WRITE=0 for 20 cycles, SHALL see BUSYWAIT=0 and READ_DATA unchanged throughout.
